pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV pipeline. Merges the hazard unit's

---
 rtl/pipeline_ctrl_pkg.sv | 113 +++++++++++
 rtl/pipeline_ctrl_sat_counter.sv | 26 ++
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, action codes,
// per-stage control bundle and the common RUN-priority evaluation.
`default_nettype none

package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_DMEM_WAIT   = 2'd1,
    ST_MULDIV_WAIT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_FREEZE = 3'd1,
    ACT_MDHOLD = 3'd2,
    ACT_REDIR  = 3'd3,
    ACT_LDUSE  = 3'd4,
    ACT_IWAIT  = 3'd5
  } action_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  typedef struct packed {
    action_t act;
    state_t  nxt;
  } decision_t;

  function automatic ctrl_t decode_action(input action_t act);
    ctrl_t c;
    c.pc_we        = 1'b1;
    c.if_id_we     = 1'b1;
    c.id_ex_we     = 1'b1;
    c.ex_mem_we    = 1'b1;
    c.mem_wb_we    = 1'b1;
    c.if_id_flush  = 1'b0;
    c.id_ex_flush  = 1'b0;
    c.ex_mem_flush = 1'b0;
    case (act)
      ACT_FREEZE: begin
        c.pc_we     = 1'b0;
        c.if_id_we  = 1'b0;
        c.id_ex_we  = 1'b0;
        c.ex_mem_we = 1'b0;
        c.mem_wb_we = 1'b0;
      end
      ACT_MDHOLD: begin
        c.pc_we        = 1'b0;
        c.if_id_we     = 1'b0;
        c.id_ex_we     = 1'b0;
        c.ex_mem_flush = 1'b1;
      end
      ACT_REDIR: begin
        c.if_id_flush = 1'b1;
        c.id_ex_flush = 1'b1;
      end
      ACT_LDUSE: begin
        c.pc_we       = 1'b0;
        c.if_id_we    = 1'b0;
        c.id_ex_flush = 1'b1;
      end
      ACT_IWAIT: begin
        c.pc_we       = 1'b0;
        c.if_id_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // dmem_en / ex_en let the wait states drop the term they are already resolving.
  function automatic decision_t run_priority(
    input logic dmem_en,
    input logic ex_en,
    input logic dmem_req,
    input logic dmem_rdy,
    input logic md_start,
    input logic md_done,
    input logic br_taken,
    input logic load_use,
    input logic imem_rdy
  );
    decision_t d;
    d.act = ACT_NONE;
    d.nxt = ST_RUN;
    if (dmem_en && dmem_req && !dmem_rdy) begin
      d.act = ACT_FREEZE;
      d.nxt = ST_DMEM_WAIT;
    end else if (ex_en && md_start && !md_done) begin
      d.act = ACT_MDHOLD;
      d.nxt = ST_MULDIV_WAIT;
    end else if (br_taken) begin
      d.act = ACT_REDIR;
    end else if (load_use) begin
      d.act = ACT_LDUSE;
    end else if (!imem_rdy) begin
      d.act = ACT_IWAIT;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory, mul/div, branch and
// hazard stalls into per-stage write enables and flushes, with stall counter and watchdog.
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LoadUseStall,
  input  logic             BranchTaken_EX,
  input  logic             IMemReady,
  input  logic             DMemReq_MEM,
  input  logic             DMemReady,
  input  logic             MulDivStart_EX,
  input  logic             MulDivDone,
  output logic             PCWriteEnable,
  output logic             WriteEnable_IF_ID,
  output logic             WriteEnable_ID_EX,
  output logic             WriteEnable_EX_MEM,
  output logic             WriteEnable_MEM_WB,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Flush_EX_MEM,
  output logic [CNT_W-1:0] StallCount,
  output logic             MulDivTimeout
);

  localparam int WD_W = $clog2(MD_TIMEOUT) + 1;

  state_t          state;
  state_t          state_nxt;
  action_t         act;
  ctrl_t           ctrl;
  decision_t       dec_run;
  decision_t       dec_dmem;
  decision_t       dec_md;
  logic            wd_fire;
  logic            wd_expired;
  logic            in_md_wait;
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  always_comb begin
    dec_run  = run_priority(1'b1, 1'b1, DMemReq_MEM, DMemReady, MulDivStart_EX, MulDivDone,
                            BranchTaken_EX, LoadUseStall, IMemReady);
    dec_dmem = run_priority(1'b0, 1'b1, DMemReq_MEM, DMemReady, MulDivStart_EX, MulDivDone,
                            BranchTaken_EX, LoadUseStall, IMemReady);
    dec_md   = run_priority(1'b0, 1'b0, DMemReq_MEM, DMemReady, MulDivStart_EX, MulDivDone,
                            BranchTaken_EX, LoadUseStall, IMemReady);
  end

  assign in_md_wait = (state == ST_MULDIV_WAIT);
  // wd_cnt holds the number of MULDIV_WAIT cycles already completed, so the
  // MD_TIMEOUT-th cycle in the state is the one that fires.
  assign wd_expired = (wd_cnt >= WD_W'(MD_TIMEOUT - 1));

  always_comb begin
    act       = ACT_NONE;
    state_nxt = ST_RUN;
    wd_fire   = 1'b0;
    case (state)
      ST_RUN: begin
        act       = dec_run.act;
        state_nxt = dec_run.nxt;
      end
      ST_DMEM_WAIT: begin
        if (!DMemReady) begin
          act       = ACT_FREEZE;
          state_nxt = ST_DMEM_WAIT;
        end else begin
          act       = dec_dmem.act;
          state_nxt = dec_dmem.nxt;
        end
      end
      ST_MULDIV_WAIT: begin
        if (MulDivDone) begin
          act       = dec_md.act;
          state_nxt = dec_md.nxt;
        end else if (wd_expired) begin
          act       = ACT_REDIR;
          state_nxt = ST_RUN;
          wd_fire   = 1'b1;
        end else begin
          act       = ACT_MDHOLD;
          state_nxt = ST_MULDIV_WAIT;
        end
      end
      default: begin
        act       = ACT_NONE;
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (wd_fire) begin
      timeout_q <= 1'b1;
    end
  end

  always_comb begin
    ctrl = decode_action(act);
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  assign PCWriteEnable      = ctrl.pc_we;
  assign WriteEnable_IF_ID  = ctrl.if_id_we;
  assign WriteEnable_ID_EX  = ctrl.id_ex_we;
  assign WriteEnable_EX_MEM = ctrl.ex_mem_we;
  assign WriteEnable_MEM_WB = ctrl.mem_wb_we;
  assign Flush_IF_ID        = ctrl.if_id_flush;
  assign Flush_ID_EX        = ctrl.id_ex_flush;
  assign Flush_EX_MEM       = ctrl.ex_mem_flush;
  assign MulDivTimeout      = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (!PCWriteEnable),
    .q     (StallCount)
  );

  // Held at zero outside MULDIV_WAIT, which clears it on every entry.
  sat_counter #(.W(WD_W)) u_md_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_md_wait),
    .inc   (in_md_wait),
    .q     (wd_cnt)
  );

endmodule

`default_nettype wire
